// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: walks each instruction
// through fetch/decode/execute/memory/write-back and drives the datapath strobes.
module mips_multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic             BranchNE,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [3:0]       State,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_DONE    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_DONE = 4'd11
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [5:0] op_q;
    logic       illegal_next;
    logic       count_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            op_q        <= '0;
            instr_count <= '0;
            illegal_op  <= 1'b0;
        end else begin
            state      <= next_state;
            illegal_op <= illegal_next;
            if (state == DECODE) begin
                op_q <= Op;
            end
            if (count_en) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // DECODE dispatches on the live opcode; op_q is only valid from the next state onward.
    always_comb begin
        next_state   = FETCH;
        illegal_next = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        ALUSrcA      = 1'b0;
        BranchNE     = 1'b0;
        PCSource     = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;

        case (state)
            FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW:   next_state = MEM_ADDR;
                    OP_R:           next_state = EXECUTE;
                    OP_BEQ, OP_BNE: next_state = BRANCH;
                    OP_J:           next_state = JUMP;
                    OP_ADDI:        next_state = ADDI_EXEC;
                    default: begin
                        next_state   = FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                next_state = mem_ready ? FETCH : MEM_WRITE;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                next_state = R_DONE;
            end
            R_DONE: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = (op_q == OP_BNE);
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ADDI_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = ADDI_DONE;
            end
            ADDI_DONE: begin
                RegWrite = 1'b1;
            end
            default: next_state = FETCH;
        endcase

        // The only DECODE->FETCH transition is the illegal-opcode path, which does not retire.
        count_en = (state != FETCH) && (state != DECODE) && (next_state == FETCH);

        State = state;
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            ALUSrcA     = 1'b0;
            BranchNE    = 1'b0;
            PCSource    = 2'b00;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            State       = 4'd0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Table-driven bench for mips_multicycle_control: per-cycle vectors of inputs and
// hand-derived state/strobe expectations, plus counter-wrap and reset-abort sequences.
module tb_mips_multicycle_control;

    localparam int CNT_W = 4;

    // Strobe word: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
    //               RegWrite, RegDst, ALUSrcA, BranchNE, PCSource[1:0], ALUSrcB[1:0], ALUOp[1:0]}
    localparam logic [16:0] C_ZERO       = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_FETCH_RDY  = 17'b1_0_0_1_0_0_1_0_0_0_0_00_01_00;
    localparam logic [16:0] C_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_0_00_01_00;
    localparam logic [16:0] C_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_0_00_11_00;
    localparam logic [16:0] C_ADDR       = 17'b0_0_0_0_0_0_0_0_0_1_0_00_10_00;
    localparam logic [16:0] C_MEM_READ   = 17'b0_0_1_1_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_MEM_WB     = 17'b0_0_0_0_0_1_0_1_0_0_0_00_00_00;
    localparam logic [16:0] C_MEM_WRITE  = 17'b0_0_1_0_1_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_EXECUTE    = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_10;
    localparam logic [16:0] C_R_DONE     = 17'b0_0_0_0_0_0_0_1_1_0_0_00_00_00;
    localparam logic [16:0] C_BR_NE      = 17'b0_1_0_0_0_0_0_0_0_1_1_01_00_01;
    localparam logic [16:0] C_BR_EQ      = 17'b0_1_0_0_0_0_0_0_0_1_0_01_00_01;
    localparam logic [16:0] C_JUMP       = 17'b1_0_0_0_0_0_0_0_0_0_0_10_00_00;
    localparam logic [16:0] C_ADDI_DONE  = 17'b0_0_0_0_0_0_0_1_0_0_0_00_00_00;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        logic [5:0]       op;
        logic             mr;
        logic [3:0]       st;
        logic [16:0]      ctrl;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic             clk;
    logic             reset;
    logic [5:0]       op;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic             IRWrite, RegWrite, RegDst, ALUSrcA, BranchNE;
    logic [1:0]       PCSource, ALUSrcB, ALUOp;
    logic [3:0]       State;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;
    logic [16:0]      ctrl;

    int   checks;
    int   failures;
    vec_t vecs[$];
    logic [CNT_W-1:0] exp_cnt;

    mips_multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .BranchNE(BranchNE), .PCSource(PCSource),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .State(State),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   RegWrite, RegDst, ALUSrcA, BranchNE, PCSource, ALUSrcB, ALUOp};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic applyStimulus(input logic [5:0] o, input logic mr, input logic rst);
        @(posedge clk);
        #1;
        op        = o;
        mem_ready = mr;
        reset     = rst;
        @(negedge clk);
    endtask

    task automatic compareField(input string tag, input string field,
                                input logic [16:0] got, input logic [16:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s %s: got %b expected %b", tag, field, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] st, input logic [16:0] c,
                               input logic ill, input logic [CNT_W-1:0] cnt);
        compareField(tag, "State", 17'(State), 17'(st));
        compareField(tag, "strobes", ctrl, c);
        compareField(tag, "illegal_op", 17'(illegal_op), 17'(ill));
        compareField(tag, "instr_count", 17'(instr_count), 17'(cnt));
    endtask

    task automatic addVec(input logic [5:0] o, input logic mr, input logic [3:0] st,
                          input logic [16:0] c, input logic ill, input logic [CNT_W-1:0] cnt);
        vec_t v;
        v.op   = o;
        v.mr   = mr;
        v.st   = st;
        v.ctrl = c;
        v.ill  = ill;
        v.cnt  = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        op        = OP_R;
        mem_ready = 1'b1;

        // R-type with mem_ready dropped in EXECUTE, which must be ignored
        addVec(OP_R,    1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 4'd0);
        addVec(OP_R,    1'b1, 4'd1,  C_DECODE,     1'b0, 4'd0);
        addVec(OP_LW,   1'b0, 4'd6,  C_EXECUTE,    1'b0, 4'd0);
        addVec(OP_R,    1'b1, 4'd7,  C_R_DONE,     1'b0, 4'd0);
        // lw with two wait cycles in MEM_READ
        addVec(OP_LW,   1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 4'd1);
        addVec(OP_LW,   1'b1, 4'd1,  C_DECODE,     1'b0, 4'd1);
        addVec(OP_LW,   1'b1, 4'd2,  C_ADDR,       1'b0, 4'd1);
        addVec(OP_LW,   1'b0, 4'd3,  C_MEM_READ,   1'b0, 4'd1);
        addVec(OP_LW,   1'b0, 4'd3,  C_MEM_READ,   1'b0, 4'd1);
        addVec(OP_LW,   1'b1, 4'd3,  C_MEM_READ,   1'b0, 4'd1);
        addVec(OP_LW,   1'b1, 4'd4,  C_MEM_WB,     1'b0, 4'd1);
        // bne then beq; Op is swapped during BRANCH to show only the latched opcode matters
        addVec(OP_BNE,  1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 4'd2);
        addVec(OP_BNE,  1'b0, 4'd1,  C_DECODE,     1'b0, 4'd2);
        addVec(OP_BEQ,  1'b1, 4'd8,  C_BR_NE,      1'b0, 4'd2);
        addVec(OP_BEQ,  1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 4'd3);
        addVec(OP_BEQ,  1'b1, 4'd1,  C_DECODE,     1'b0, 4'd3);
        addVec(OP_BNE,  1'b1, 4'd8,  C_BR_EQ,      1'b0, 4'd3);
        // illegal opcode, then a FETCH wait cycle while illegal_op pulses
        addVec(OP_BAD,  1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 4'd4);
        addVec(OP_BAD,  1'b1, 4'd1,  C_DECODE,     1'b0, 4'd4);
        addVec(OP_ADDI, 1'b0, 4'd0,  C_FETCH_WAIT, 1'b1, 4'd4);
        addVec(OP_ADDI, 1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 4'd4);
        // addi
        addVec(OP_ADDI, 1'b1, 4'd1,  C_DECODE,     1'b0, 4'd4);
        addVec(OP_ADDI, 1'b1, 4'd10, C_ADDR,       1'b0, 4'd4);
        addVec(OP_ADDI, 1'b1, 4'd11, C_ADDI_DONE,  1'b0, 4'd4);
        // sw with one wait cycle in MEM_WRITE
        addVec(OP_SW,   1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 4'd5);
        addVec(OP_SW,   1'b1, 4'd1,  C_DECODE,     1'b0, 4'd5);
        addVec(OP_SW,   1'b1, 4'd2,  C_ADDR,       1'b0, 4'd5);
        addVec(OP_SW,   1'b0, 4'd5,  C_MEM_WRITE,  1'b0, 4'd5);
        addVec(OP_SW,   1'b1, 4'd5,  C_MEM_WRITE,  1'b0, 4'd5);
        // jump
        addVec(OP_J,    1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 4'd6);
        addVec(OP_J,    1'b1, 4'd1,  C_DECODE,     1'b0, 4'd6);
        addVec(OP_J,    1'b1, 4'd9,  C_JUMP,       1'b0, 4'd6);
        addVec(OP_J,    1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 4'd7);

        #2;
        compareField("pre_edge_reset", "State", 17'(State), 17'd0);
        compareField("pre_edge_reset", "strobes", ctrl, C_ZERO);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(OP_R, 1'b1, 1'b1);
            checkOutput($sformatf("reset%0d", i), 4'd0, C_ZERO, 1'b0, 4'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].mr, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl, vecs[i].ill, vecs[i].cnt);
        end

        // 16 jumps on a 4-bit counter: wraps 15->0 and comes back to where it started
        exp_cnt = 4'd7;
        for (int n = 0; n < 16; n++) begin
            applyStimulus(OP_J, 1'b1, 1'b0);
            checkOutput($sformatf("wrap%0d_decode", n), 4'd1, C_DECODE, 1'b0, exp_cnt);
            applyStimulus(OP_J, 1'b1, 1'b0);
            checkOutput($sformatf("wrap%0d_jump", n), 4'd9, C_JUMP, 1'b0, exp_cnt);
            exp_cnt = (exp_cnt == 4'd15) ? 4'd0 : exp_cnt + 4'd1;
            applyStimulus(OP_J, 1'b1, 1'b0);
            checkOutput($sformatf("wrap%0d_fetch", n), 4'd0, C_FETCH_RDY, 1'b0, exp_cnt);
        end

        // Reset while a store is waiting on memory aborts it without retiring
        applyStimulus(OP_SW, 1'b1, 1'b0);
        checkOutput("abort_decode", 4'd1, C_DECODE, 1'b0, exp_cnt);
        applyStimulus(OP_SW, 1'b1, 1'b0);
        checkOutput("abort_addr", 4'd2, C_ADDR, 1'b0, exp_cnt);
        applyStimulus(OP_SW, 1'b0, 1'b0);
        checkOutput("abort_memwrite", 4'd5, C_MEM_WRITE, 1'b0, exp_cnt);
        applyStimulus(OP_SW, 1'b1, 1'b1);
        checkOutput("abort_reset", 4'd0, C_ZERO, 1'b0, exp_cnt);
        applyStimulus(OP_SW, 1'b1, 1'b0);
        checkOutput("abort_fetch", 4'd0, C_FETCH_RDY, 1'b0, 4'd0);
        applyStimulus(OP_SW, 1'b1, 1'b0);
        checkOutput("abort_redecode", 4'd1, C_DECODE, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
